// File: rtl/image_update_sequencer_if.sv
// Bundle of every non-clock signal of image_update_sequencer.
//
// Host request channel (valid/ready):
//   A request transfers on a rising clk edge where req_valid && req_ready are both
//   high. req_op and req_image must be stable whenever req_valid is high. The host
//   keeps req_valid (and its payload) asserted until that edge. Requests offered
//   while req_ready is low are neither queued nor remembered.
//
// Signals:
//   req_valid, req_op, req_image  host -> sequencer request
//   req_ready, busy               sequencer availability
//   cur_image, status_valid       last captured image code and its update strobe
//   err_timeout                   sticky read-timeout flag
//   start_getimg, start_setimg    one-cycle command pulses to ImageControl
//   setimg                        image code for the switch command
//   getimg, done_getimg           read result and completion strobe from ImageControl
//
// Modports: slave = the sequencer, master = whoever drives it (host + ImageControl).
interface image_update_sequencer_if;
    logic       req_valid;
    logic       req_op;
    logic [1:0] req_image;
    logic       req_ready;
    logic       busy;
    logic [3:0] cur_image;
    logic       status_valid;
    logic       err_timeout;
    logic       start_getimg;
    logic       start_setimg;
    logic [1:0] setimg;
    logic [3:0] getimg;
    logic       done_getimg;

    modport slave (
        input  req_valid, req_op, req_image, getimg, done_getimg,
        output req_ready, busy, cur_image, status_valid, err_timeout,
               start_getimg, start_setimg, setimg
    );

    modport master (
        output req_valid, req_op, req_image, getimg, done_getimg,
        input  req_ready, busy, cur_image, status_valid, err_timeout,
               start_getimg, start_setimg, setimg
    );
endinterface

// File: rtl/image_update_sequencer.sv
// Command sequencer in front of the ImageControl remote-update engine.
// Turns host read/switch requests into single-cycle start_getimg/start_setimg
// pulses, captures the getimg result, guards each read with a timeout and runs
// one automatic image read after reset.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   bus        image_update_sequencer_if.slave (host request channel, status,
//              ImageControl command/response signals)
//   dbg_state  current FSM state, for observation only
//
// All outputs come straight from flops. Each flop <sig>_q is loaded from <sig>_d,
// and the output flops are computed from the next state so they line up with it.
module image_update_sequencer #(
    parameter int TIMEOUT_CYC  = 255,
    parameter int SET_HOLD_CYC = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    image_update_sequencer_if.slave        bus,
    output logic [2:0]                     dbg_state
);
    localparam int CNT_MAX = (TIMEOUT_CYC > SET_HOLD_CYC) ? TIMEOUT_CYC : SET_HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SET_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_GET_START = 3'd2,
        ST_GET_WAIT  = 3'd3,
        ST_SET_START = 3'd4,
        ST_SET_HOLD  = 3'd5
    } state_t;

    state_t           state_q,        state_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic             req_ready_q,    req_ready_d;
    logic             busy_q,         busy_d;
    logic [3:0]       cur_image_q,    cur_image_d;
    logic             status_valid_q, status_valid_d;
    logic             err_timeout_q,  err_timeout_d;
    logic             start_getimg_q, start_getimg_d;
    logic             start_setimg_q, start_setimg_d;
    logic [1:0]       setimg_q,       setimg_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             handshake;

    always_comb begin
        // Saturating increment: the counter parks at all-ones instead of wrapping.
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
        handshake = bus.req_valid && req_ready_q;

        state_d        = state_q;
        cnt_d          = cnt_q;
        cur_image_d    = cur_image_q;
        status_valid_d = 1'b0;
        err_timeout_d  = err_timeout_q;
        setimg_d       = setimg_q;
        start_setimg_d = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_GET_START;
                cnt_d   = '0;
            end

            ST_IDLE: begin
                if (handshake) begin
                    err_timeout_d = 1'b0;
                    cnt_d         = '0;
                    if (bus.req_op) begin
                        setimg_d = bus.req_image;
                        state_d  = ST_SET_START;
                    end else begin
                        state_d  = ST_GET_START;
                    end
                end
            end

            // Counter is 0 here and equals the number of GET_WAIT cycles elapsed
            // (including the current one) while waiting.
            ST_GET_START: begin
                cnt_d   = cnt_inc;
                state_d = ST_GET_WAIT;
            end

            ST_GET_WAIT: begin
                if (bus.done_getimg) begin
                    // done is tested first so it wins over the terminal count.
                    cur_image_d    = bus.getimg;
                    status_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end else if (cnt_q >= TO_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Two cycles: the first lets the freshly registered setimg settle,
            // the pulse flop is loaded during it so start_setimg appears in the
            // second cycle with setimg already stable for a full cycle.
            ST_SET_START: begin
                if (cnt_q == '0) begin
                    start_setimg_d = 1'b1;
                    cnt_d          = cnt_inc;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_SET_HOLD;
                end
            end

            // Normally ImageControl reconfigures the device (and resets us)
            // inside this window; surviving it means verifying with a read.
            ST_SET_HOLD: begin
                if (cnt_q >= HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GET_START;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        start_getimg_d = (state_d == ST_GET_START);
        req_ready_d    = (state_d == ST_IDLE);
        busy_d         = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BOOT;
            cnt_q          <= '0;
            req_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
            cur_image_q    <= 4'h0;
            status_valid_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            start_getimg_q <= 1'b0;
            start_setimg_q <= 1'b0;
            setimg_q       <= 2'b00;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
            cur_image_q    <= cur_image_d;
            status_valid_q <= status_valid_d;
            err_timeout_q  <= err_timeout_d;
            start_getimg_q <= start_getimg_d;
            start_setimg_q <= start_setimg_d;
            setimg_q       <= setimg_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.busy         = busy_q;
    assign bus.cur_image    = cur_image_q;
    assign bus.status_valid = status_valid_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.start_getimg = start_getimg_q;
    assign bus.start_setimg = start_setimg_q;
    assign bus.setimg       = setimg_q;
    assign dbg_state        = state_q;
endmodule
